// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - shift-and-add multiply-accumulate sequencer with valid/ready handshakes
// Optional feature macro: MAC_SATURATE_EN (saturate ACC on accumulate overflow instead of wrapping)
module mac_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 CLEAR,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [ACC_WIDTH-1:0] ACC,
  output logic                 OVF,
  output logic                 BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 clear_q;
  logic [2*WIDTH-1:0]   prod;
  logic [CW-1:0]        cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;

  logic [WIDTH-1:0]     pp_row;
  logic [2*WIDTH-1:0]   pp_shifted;
  logic [ACC_WIDTH:0]   sum;

  assign pp_row     = a_q & {WIDTH{b_q[cnt]}};
  assign pp_shifted = (2*WIDTH)'(pp_row) << cnt;
  assign sum        = {1'b0, acc} + (ACC_WIDTH+1)'(prod);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    BUSY       = 1'b1;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        BUSY     = 1'b0;
        if (IN_VALID) begin
          state_next = MULT;
        end
      end
      MULT: begin
        if (cnt == LAST_BIT) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        state_next = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      clear_q <= 1'b0;
      prod    <= '0;
      cnt     <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_q     <= A;
            b_q     <= B;
            clear_q <= CLEAR;
            prod    <= '0;
            cnt     <= '0;
          end
        end
        MULT: begin
          prod <= prod + pp_shifted;
          cnt  <= cnt + 1'b1;
        end
        ACCUM: begin
          if (clear_q) begin
            acc <= ACC_WIDTH'(prod);
            ovf <= 1'b0;
          end else begin
`ifdef MAC_SATURATE_EN
            // Once saturated, stay pinned at all ones until a CLEAR op.
            if (ovf || sum[ACC_WIDTH]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= sum[ACC_WIDTH-1:0];
            end
`else
            acc <= sum[ACC_WIDTH-1:0];
            ovf <= ovf | sum[ACC_WIDTH];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ACC = acc;
  assign OVF = ovf;

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the MAC datapath. Accepts an operand pair over a valid/ready handshake and multiplies it by iterating over the bit-wise AND partial-product rows, one row per cycle (shift-and-add). It then adds the product into an accumulator and presents the result on a valid/ready output. It sits between the operand source and the result consumer, and owns the accumulator register.

Parameters:
WIDTH, 8, operand width in bits (unsigned A and B)
ACC_WIDTH, 20, accumulator width in bits; must be >= 2*WIDTH

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  reset, asynchronous, active-high
IN_VALID  input  1  operand pair valid
IN_READY  output  1  block can accept an operand pair
A  input  WIDTH  multiplicand
B  input  WIDTH  multiplier
CLEAR  input  1  sampled with A/B; zero the accumulator before adding this product
OUT_VALID  output  1  ACC holds an updated result
OUT_READY  input  1  consumer accepts the result
ACC  output  ACC_WIDTH  accumulator value
OVF  output  1  sticky overflow flag
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-high (RST).
- Reset values: all registers 0. State = IDLE, IN_READY=1, OUT_VALID=0, ACC=0, OVF=0, BUSY=0.
- Reset mid-operation immediately aborts the operation and clears all registers. No partial result is ever emitted.
- State IDLE:
  - IN_READY=1.
  - When IN_VALID=1 (handshake), latch A, B and CLEAR into internal registers, clear the product register and bit counter, and go to MULT.
- State MULT, WIDTH cycles, counter i = 0..WIDTH-1:
  - product += (A AND {WIDTH{B[i]}}) << i. The product register is 2*WIDTH bits wide.
  - After i = WIDTH-1, go to ACCUM.
- State ACCUM, 1 cycle:
  - If CLEAR was latched: ACC = zero-extended product, and OVF is cleared.
  - Otherwise: ACC = ACC + product computed at ACC_WIDTH+1 bits; on carry-out, wrap and set OVF=1.
  - Go to DONE.
- State DONE:
  - OUT_VALID=1; ACC and OVF are stable.
  - When OUT_READY=1, go to IDLE.
- Latency: handshake at cycle 0, MULT at cycles 1..WIDTH, ACCUM at cycle WIDTH+1, OUT_VALID first high at cycle WIDTH+2 (cycle 10 for WIDTH=8).
- With OUT_READY held at 1, throughput is one operation per WIDTH+3 cycles (one IDLE cycle included).
- IN_READY is 0 in MULT, ACCUM and DONE. IN_VALID in those states is ignored and not queued.
- A and B may change freely after the handshake; only the latched copies are used.
- OVF is sticky and clears only on RST or on an op with CLEAR=1.
- Operands of 0 still take the full latency; the result equals ACC unchanged (or 0 if CLEAR=1).

Optional Feature:
MAC_SATURATE_EN
- Defined: on accumulate carry-out, ACC = all ones (2^ACC_WIDTH-1) and OVF=1. While OVF=1 and CLEAR=0, ACC stays at all ones.
- Undefined: the wrap-around behaviour described above.

Test Plan:
- Reset, then A=3, B=5, CLEAR=1, OUT_READY=1 -> OUT_VALID at cycle 10, ACC=15, OVF=0, BUSY high for cycles 1..10.
- Follow-up A=255, B=255, CLEAR=0 -> ACC=65040, OVF=0. During the op, IN_VALID pulses with A=7 are ignored and IN_READY=0.
- 17 ops of 255*255, first with CLEAR=1 -> without the macro ACC=56849, OVF=1; with MAC_SATURATE_EN, ACC=1048575, OVF=1. A next op of 2*2 with CLEAR=1 gives ACC=4, OVF=0.
- A=12, B=10, CLEAR=1, OUT_READY=0 for 20 cycles -> OUT_VALID stays 1, ACC=120 stable, IN_READY=0. Raising OUT_READY returns the block to IDLE on the next cycle.
- Start A=200, B=100; assert RST at cycle 4 -> all outputs return to reset values at once. After release, A=1, B=1, CLEAR=1 gives ACC=1.
- A=0, B=255, CLEAR=0 after ACC=15 -> OUT_VALID at cycle 10, ACC=15.
